// File: rtl/tree_sum_accumulator.sv
// tree_sum_accumulator
//   Accumulates a programmable number of consecutive tree sums into one wider
//   result and returns it over a valid/ready handshake. The adder tree carries
//   no valid signal, so the issuing side's valid is delayed here by the tree
//   latency to line it up with sum_in.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      single-cycle pulse that begins a new accumulation
//   len        number of tree sums to accumulate, sampled with start
//   in_valid   high in the cycle the tree inputs are presented
//   sum_in     tree output, unsigned
//   out_data   accumulated result (equals the accumulator register)
//   out_valid  result available
//   out_ready  consumer accepts the result
//   busy       high while accumulating or holding a result
//   overflow   sticky saturation flag, cleared by an accepted start
//   drop       sticky flag: an aligned valid arrived outside accumulation
module tree_sum_accumulator #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 24,
  parameter int LAT   = 5,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  sum_in,
  output logic [ACC_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overflow,
  output logic             drop
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_HOLD} state_t;

  state_t           state_q;
  logic [LAT-1:0]   vdly_q;
  logic [LAT-1:0]   vdly_d;
  logic             v_al;
  logic [LEN_W-1:0] cnt_q;
  logic [ACC_W-1:0] acc_q;
  logic             busy_q;
  logic             out_valid_q;
  logic             overflow_q;
  logic             drop_q;
  logic [ACC_W:0]   sum_wide;
  logic             add_ovf;
  logic [ACC_W-1:0] acc_d;
  logic             start_ok;

  // Valid delay line; a single-stage line has nothing to shift from.
  generate
    if (LAT == 1) begin : g_dly_one
      assign vdly_d = in_valid;
    end else begin : g_dly_many
      assign vdly_d = {vdly_q[LAT-2:0], in_valid};
    end
  endgenerate

  assign v_al = vdly_q[LAT-1];

  // One extra bit catches the carry; once saturated, any non-zero addend
  // carries out again, so the accumulator stays pinned at all-ones.
  assign sum_wide = {1'b0, acc_q} + (ACC_W+1)'(sum_in);
  assign add_ovf  = sum_wide[ACC_W];
  assign acc_d    = add_ovf ? '1 : sum_wide[ACC_W-1:0];

  assign start_ok = start && (len != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      vdly_q      <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      vdly_q <= vdly_d;
      case (state_q)
        S_IDLE: begin
          if (v_al) drop_q <= 1'b1;
          if (start_ok) begin
            state_q    <= S_ACC;
            cnt_q      <= len;
            acc_q      <= '0;
            overflow_q <= 1'b0;
            // A valid landing on the start edge belongs to no pass yet.
            drop_q     <= v_al;
            busy_q     <= 1'b1;
          end
        end
        S_ACC: begin
          if (v_al) begin
            acc_q <= acc_d;
            if (add_ovf) overflow_q <= 1'b1;
            cnt_q <= cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1)) begin
              state_q     <= S_HOLD;
              busy_q      <= 1'b1;
              out_valid_q <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (v_al) drop_q <= 1'b1;
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            if (start_ok) begin
              state_q    <= S_ACC;
              cnt_q      <= len;
              acc_q      <= '0;
              overflow_q <= 1'b0;
              drop_q     <= v_al;
              busy_q     <= 1'b1;
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_data  = acc_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign overflow  = overflow_q;
  assign drop      = drop_q;

endmodule

// File: tb/tb_tree_sum_accumulator.sv
// Testbench for tree_sum_accumulator: a default-width instance and a 17-bit
// accumulator instance for the saturation case. Expected results are queued
// when a pass is started and popped on each output handshake.
module tb_tree_sum_accumulator;

  localparam int LAT = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_m, start_s;
  logic [7:0]  len;
  logic        iv_m, iv_s;
  logic [15:0] sum_in;
  logic        out_ready;
  logic [23:0] data_m;
  logic [16:0] data_s;
  logic        ov_m, ov_s, busy_m, busy_s, ovf_m, ovf_s, drop_m, drop_s;

  always #5 clk = ~clk;

  tree_sum_accumulator #(.IN_W(16), .ACC_W(24), .LAT(LAT), .LEN_W(8)) dut_m (
    .clk(clk), .reset(reset), .start(start_m), .len(len), .in_valid(iv_m),
    .sum_in(sum_in), .out_data(data_m), .out_valid(ov_m), .out_ready(out_ready),
    .busy(busy_m), .overflow(ovf_m), .drop(drop_m));

  tree_sum_accumulator #(.IN_W(16), .ACC_W(17), .LAT(LAT), .LEN_W(8)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .len(len), .in_valid(iv_s),
    .sum_in(sum_in), .out_data(data_s), .out_valid(ov_s), .out_ready(out_ready),
    .busy(busy_s), .overflow(ovf_s), .drop(drop_s));

  typedef struct {
    int       sel;      // 0: default instance, 1: 17-bit instance
    int       len;
    int       n;        // number of in_valid cycles described by pat
    bit [7:0] pat;      // pat[k]: in_valid in cycle k after start
    int       vals[8];  // vals[k]: tree sum belonging to cycle k
    int       exp;
    bit       ovf;
  } vec_t;

  typedef struct { int data; bit ovf; } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec  = 0;
  int   n_miss = 0;
  int   cur_sel = 0;

  // Observed outputs of whichever instance the current pass targets.
  logic [31:0] c_data;
  logic        c_ov, c_busy, c_ovf, c_drop;
  always_comb begin
    c_data = (cur_sel == 1) ? 32'(data_s) : 32'(data_m);
    c_ov   = (cur_sel == 1) ? ov_s   : ov_m;
    c_busy = (cur_sel == 1) ? busy_s : busy_m;
    c_ovf  = (cur_sel == 1) ? ovf_s  : ovf_m;
    c_drop = (cur_sel == 1) ? drop_s : drop_m;
  end

  task automatic chk(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_miss++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every accepted result is compared with the oldest entry.
  always @(negedge clk) begin
    if (!reset && out_ready && (ov_m || ov_s)) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL handshake: got unexpected result, required none");
      end else begin
        mon_e = exp_q.pop_front();
        $display("result accepted: data=%0d overflow=%0b (expected %0d/%0b)",
                 ov_m ? 32'(data_m) : 32'(data_s), ov_m ? ovf_m : ovf_s,
                 mon_e.data, mon_e.ovf);
        chk("hs_data", ov_m ? 32'(data_m) : 32'(data_s), mon_e.data);
        chk("hs_ovf", ov_m ? ovf_m : ovf_s, mon_e.ovf);
      end
    end
  end

  task automatic idle_inputs();
    start_m = 0; start_s = 0; iv_m = 0; iv_s = 0;
    len = 0; sum_in = 16'h0000; out_ready = 0;
  endtask

  // Runs one pass up to the completion edge. rdy0 raises out_ready with the
  // start pulse (back-to-back with a held result); poke re-pulses start
  // during accumulation, which must be ignored.
  task automatic run_pass(input vec_t v, input bit rdy0, input int poke);
    int   last_k;
    int   klast;
    exp_t e;
    last_k = 0;
    for (int i = 0; i < v.n; i++) if (v.pat[i]) last_k = i;
    klast = LAT + last_k;
    e.data = v.exp; e.ovf = v.ovf;
    exp_q.push_back(e);
    cur_sel = v.sel;
    for (int k = 0; k <= klast; k++) begin
      logic st, ivb;
      st  = (k == 0) || (k == poke);
      ivb = (k < v.n) ? v.pat[k] : 1'b0;
      start_m = (v.sel == 0) ? st : 1'b0;
      start_s = (v.sel == 1) ? st : 1'b0;
      iv_m    = (v.sel == 0) ? ivb : 1'b0;
      iv_s    = (v.sel == 1) ? ivb : 1'b0;
      len     = (k == 0) ? 8'(v.len) : 8'd7;
      out_ready = (k == 0) ? rdy0 : 1'b0;
      // Garbage on sum_in whenever no aligned valid is due.
      if (k >= LAT && (k - LAT) < v.n && v.pat[k-LAT]) sum_in = 16'(v.vals[k-LAT]);
      else sum_in = 16'hBEEF;
      tick();
      chk("out_valid", c_ov, (k == klast) ? 1 : 0);
      chk("busy", c_busy, 1);
      if (k == klast) begin
        chk("out_data", c_data, v.exp);
        chk("overflow", c_ovf, v.ovf);
        chk("drop", c_drop, 0);
      end
    end
    idle_inputs();
  endtask

  task automatic finish_hold(input int exp);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("hold_valid", c_ov, 1);
      chk("hold_data", c_data, exp);
    end
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("after_hs_valid", c_ov, 0);
    chk("after_hs_busy", c_busy, 0);
  endtask

  vec_t tbl[5];
  vec_t va, vb;

  initial begin
    tbl[0] = '{0, 4, 4, 8'b0000_1111, '{100, 200, 300, 400, 0, 0, 0, 0}, 1000, 1'b0};
    tbl[1] = '{0, 3, 3, 8'b0000_0111, '{65535, 65535, 65535, 0, 0, 0, 0, 0}, 196605, 1'b0};
    tbl[2] = '{1, 3, 3, 8'b0000_0111, '{65535, 65535, 65535, 0, 0, 0, 0, 0}, 131071, 1'b1};
    tbl[3] = '{0, 3, 5, 8'b0001_1001, '{7, 0, 0, 11, 13, 0, 0, 0}, 31, 1'b0};
    tbl[4] = '{0, 1, 1, 8'b0000_0001, '{43981, 0, 0, 0, 0, 0, 0, 0}, 43981, 1'b0};

    idle_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("rst_data", data_m, 0);
      chk("rst_valid", ov_m, 0);
      chk("rst_busy", busy_m, 0);
      chk("rst_ovf", ovf_m, 0);
      chk("rst_drop", drop_m, 0);
      chk("rst_busy_s", busy_s, 0);
    end

    // A zero-length start is ignored.
    start_m = 1; len = 0;
    tick();
    idle_inputs();
    chk("len0_busy", busy_m, 0);

    foreach (tbl[i]) begin
      run_pass(tbl[i], 1'b0, -1);
      finish_hold(tbl[i].exp);
    end

    // Back-to-back: second start rides the handshake of the first result,
    // and a start during the second accumulation is ignored.
    va = '{0, 2, 2, 8'b0000_0011, '{5, 6, 0, 0, 0, 0, 0, 0}, 11, 1'b0};
    vb = '{0, 2, 2, 8'b0000_0011, '{20, 30, 0, 0, 0, 0, 0, 0}, 50, 1'b0};
    run_pass(va, 1'b0, -1);
    run_pass(vb, 1'b1, 3);
    finish_hold(50);

    // Aligned valid while idle: drop rises exactly LAT edges later, acc kept.
    cur_sel = 0;
    iv_m = 1; sum_in = 16'h1234;
    for (int k = 0; k <= LAT; k++) begin
      tick();
      iv_m = 0;
      chk("idle_drop", drop_m, (k >= LAT) ? 1 : 0);
    end
    chk("idle_acc", data_m, 50);
    chk("idle_busy", busy_m, 0);

    // Reset in the middle of a pass with valids still in the delay line.
    start_m = 1; len = 4; iv_m = 1; sum_in = 16'h0F0F;
    tick();
    start_m = 0;
    tick(); tick();
    iv_m = 0;
    reset = 1;
    tick();
    reset = 0;
    chk("mid_rst_data", data_m, 0);
    chk("mid_rst_valid", ov_m, 0);
    chk("mid_rst_busy", busy_m, 0);
    chk("mid_rst_ovf", ovf_m, 0);
    chk("mid_rst_drop", drop_m, 0);
    for (int c = 0; c < LAT + 2; c++) begin
      tick();
      chk("post_rst_drop", drop_m, 0);
      chk("post_rst_busy", busy_m, 0);
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
